// File: rtl/mac_sequencer.sv
// Dot-product sequencer around an external combinational multiply-and-add unit.
// Pairs stream in on a valid/ready port; the finished sum is offered on a valid/ready result port.
module mac_sequencer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned LENGTH_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [LENGTH_WIDTH-1:0]   vector_length,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     input_value,
    input  logic [7:0]                weight_value,
    output logic [2*DATA_WIDTH-1:0]   mac_add_value,
    output logic [DATA_WIDTH-1:0]     mac_input_value,
    output logic [7:0]                mac_weight_value,
    input  logic [2*DATA_WIDTH-1:0]   mac_output_value,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [2*DATA_WIDTH-1:0]   result_value
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_t;

    localparam logic [LENGTH_WIDTH-1:0] LenOne = LENGTH_WIDTH'(1);

    state_t                    state;
    logic [2*DATA_WIDTH-1:0]   accumulator;
    logic [LENGTH_WIDTH-1:0]   remaining;

    // Status outputs are kept as flops so they carry no combinational input paths.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= StIdle;
            accumulator  <= '0;
            remaining    <= '0;
            busy         <= 1'b0;
            in_ready     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        accumulator <= '0;
                        busy        <= 1'b1;
                        if (vector_length != '0) begin
                            remaining <= vector_length;
                            in_ready  <= 1'b1;
                            state     <= StAccum;
                        end else begin
                            result_valid <= 1'b1;
                            state        <= StDone;
                        end
                    end
                end
                StAccum: begin
                    // in_ready is high throughout this state, so in_valid alone marks a beat.
                    if (in_valid) begin
                        accumulator <= mac_output_value;
                        remaining   <= remaining - LenOne;
                        if (remaining == LenOne) begin
                            in_ready     <= 1'b0;
                            result_valid <= 1'b1;
                            state        <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: begin
                    in_ready     <= 1'b0;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= StIdle;
                end
            endcase
        end
    end

    assign mac_add_value    = accumulator;
    assign mac_input_value  = input_value;
    assign mac_weight_value = weight_value;
    assign result_value     = accumulator;

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomized bench for mac_sequencer: an ideal MAC closes the loop, a plain integer
// dot product supplies the expected sums.
module tb_mac_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  vector_length;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  input_value;
    logic [7:0]  weight_value;
    logic [15:0] mac_add_value;
    logic [7:0]  mac_input_value;
    logic [7:0]  mac_weight_value;
    logic [15:0] mac_output_value;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] result_value;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] vec_a [64];
    logic [7:0] vec_w [64];

    mac_sequencer #(
        .DATA_WIDTH   (8),
        .LENGTH_WIDTH (8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .vector_length    (vector_length),
        .busy             (busy),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .input_value      (input_value),
        .weight_value     (weight_value),
        .mac_add_value    (mac_add_value),
        .mac_input_value  (mac_input_value),
        .mac_weight_value (mac_weight_value),
        .mac_output_value (mac_output_value),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_value     (result_value)
    );

    // Ideal external multiply-and-add unit, 16-bit wrap.
    logic signed [15:0] a_ext, w_ext, product;
    assign a_ext            = {{8{mac_input_value[7]}}, mac_input_value};
    assign w_ext            = {{8{mac_weight_value[7]}}, mac_weight_value};
    assign product          = a_ext * w_ext;
    assign mac_output_value = mac_add_value + product;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_dot(input int n);
        int sum = 0;
        for (int i = 0; i < n; i++) sum += int'($signed(vec_a[i])) * int'($signed(vec_w[i]));
        return 16'(sum);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with the sequencer idle. Runs one full vector.
    task automatic run_vector(input string tag, input int n, input int max_gap,
                              input int ready_delay, input bit hold_start);
        logic [15:0] exp;
        exp = ref_dot(n);
        start = 1'b1;
        vector_length = 8'(n);
        tick();
        if (!hold_start) start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        if (n == 0) begin
            check({tag, "_len0_valid"}, 32'(result_valid), 32'd1);
        end else begin
            check({tag, "_in_ready_accum"}, 32'(in_ready), 32'd1);
            for (int i = 0; i < n; i++) begin
                int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    tick();
                    check({tag, "_stall_no_valid"}, 32'(result_valid), 32'd0);
                end
                in_valid     = 1'b1;
                input_value  = vec_a[i];
                weight_value = vec_w[i];
                tick();
                in_valid     = 1'b0;
                input_value  = 8'($urandom);
                weight_value = 8'($urandom);
            end
            check({tag, "_valid_latency"}, 32'(result_valid), 32'd1);
        end
        check({tag, "_result"}, 32'(result_value), 32'(exp));
        check({tag, "_mac_add"}, 32'(mac_add_value), 32'(exp));
        for (int d = 0; d < ready_delay; d++) begin
            result_ready = 1'b0;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check({tag, "_hold_valid"}, 32'(result_valid), 32'd1);
            check({tag, "_hold_value"}, 32'(result_value), 32'(exp));
            check({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(result_valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        vector_length = '0;
        in_valid      = 1'b0;
        input_value   = '0;
        weight_value  = '0;
        result_ready  = 1'b0;

        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_result_value", 32'(result_value), 32'd0);
        check("rst_mac_add", 32'(mac_add_value), 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Signed sum: (2,3) (5,2) (-1,6) = 10
        vec_a[0] = 8'd2;   vec_w[0] = 8'd3;
        vec_a[1] = 8'd5;   vec_w[1] = 8'd2;
        vec_a[2] = 8'd255; vec_w[2] = 8'd6;
        check("ref_signed_sum", 32'(ref_dot(3)), 32'd10);
        run_vector("signed", 3, 0, 0, 1'b0);
        tick();
        run_vector("stall", 3, 2, 5, 1'b0);
        tick();

        for (int i = 0; i < 5; i++) begin
            vec_a[i] = 8'd127;
            vec_w[i] = 8'd127;
        end
        check("ref_wrap", 32'(ref_dot(5)), 32'd15109);
        run_vector("wrap", 5, 0, 0, 1'b0);
        tick();
        run_vector("len0", 0, 0, 0, 1'b0);
        tick();

        // Asynchronous reset after 2 of 4 beats.
        for (int i = 0; i < 4; i++) begin
            vec_a[i] = 8'd9;
            vec_w[i] = 8'd7;
        end
        start = 1'b1;
        vector_length = 8'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            input_value = vec_a[i];
            weight_value = vec_w[i];
            tick();
        end
        in_valid = 1'b0;
        check("pre_reset_partial", 32'(mac_add_value), 32'd126);
        #2 reset_n = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd0);
        check("async_mac_add", 32'(mac_add_value), 32'd0);
        check("async_result", 32'(result_value), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            vec_a[i] = 8'd1;
            vec_w[i] = 8'd1;
        end
        run_vector("post_reset", 2, 0, 0, 1'b0);

        // start held through the run: next run only after the DONE handshake.
        vec_a[0] = 8'd3; vec_w[0] = 8'd253;
        vec_a[1] = 8'd4; vec_w[1] = 8'd4;
        run_vector("held_start", 2, 1, 2, 1'b1);
        tick();
        check("held_restart_busy", 32'(busy), 32'd1);
        check("held_restart_ready", 32'(in_ready), 32'd1);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            input_value = vec_a[i];
            weight_value = vec_w[i];
            tick();
        end
        in_valid = 1'b0;
        check("held_second_result", 32'(result_value), 32'(ref_dot(2)));
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        tick();

        for (int t = 0; t < 20; t++) begin
            int n = int'($urandom_range(0, 8));
            for (int i = 0; i < n; i++) begin
                vec_a[i] = 8'($urandom);
                vec_w[i] = 8'($urandom);
            end
            run_vector("random", n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Sequential controller that drives one combinational `multiply_and_add` unit to compute a signed dot product over a vector of input/weight pairs. It accepts pairs on a valid/ready stream and feeds back its accumulator register as the MAC add operand, so one pair is absorbed per accepted beat. It presents the final sum on a valid/ready result port. It sits between the layer data fetch logic and the output buffer.

## Interface
Parameters:
- DATA_WIDTH, 8, width of `input_value`; the accumulator and result are 2*DATA_WIDTH wide.
- LENGTH_WIDTH, 8, width of `vector_length`, which sets the maximum number of pairs per dot product.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  requests a new dot product; sampled only in IDLE.
- vector_length  input  LENGTH_WIDTH  number of pairs; captured on the accepted `start`.
- busy  output  1  high in any state other than IDLE.
- in_valid  input  1  a pair is present on `input_value`/`weight_value`.
- in_ready  output  1  the sequencer accepts a pair this cycle.
- input_value  input  DATA_WIDTH  two's-complement activation.
- weight_value  input  8  two's-complement weight.
- mac_add_value  output  2*DATA_WIDTH  driven by the accumulator register.
- mac_input_value  output  DATA_WIDTH  combinational pass-through of `input_value`.
- mac_weight_value  output  8  combinational pass-through of `weight_value`.
- mac_output_value  input  2*DATA_WIDTH  MAC result, equal to add + input*weight with signed operands and 2*DATA_WIDTH wrap.
- result_valid  output  1  `result_value` holds a completed sum.
- result_ready  input  1  the consumer takes the result.
- result_value  output  2*DATA_WIDTH  the completed dot product.

## Operation
- The FSM has three states: IDLE, ACCUM and DONE.
- IDLE:
  - `start`=1 with `vector_length`≠0: clear the accumulator, load `remaining`=`vector_length`, go to ACCUM.
  - `start`=1 with `vector_length`=0: clear the accumulator, go to DONE.
  - `start`=0: stay in IDLE.
- ACCUM:
  - `in_ready`=1.
  - On each beat with `in_valid`&&`in_ready`: accumulator <= `mac_output_value` and `remaining` decrements.
  - When a beat is accepted with `remaining`=1, go to DONE.
  - If `in_valid`=0, hold all state.
- DONE:
  - `result_valid`=1 and `result_value`=accumulator.
  - When `result_ready`=1, go to IDLE.
  - `result_value` stays stable while `result_valid`=1.
- `start` is ignored outside IDLE; a held `start` is re-sampled only after returning to IDLE.
- Arithmetic is signed two's complement and wraps modulo 2^(2*DATA_WIDTH). No saturation, no overflow flag.
- `in_ready` is 0 in IDLE and DONE. `in_ready` does not depend combinationally on `in_valid`.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-vector):
  - state=IDLE, accumulator=0, `remaining`=0.
  - `busy`=0, `in_ready`=0, `result_valid`=0, `result_value`=0, `mac_add_value`=0.
  - A partially accumulated sum is discarded.
- Cycle timing for an accepted `start` at edge N:
  - ACCUM from N+1, with `in_ready` high after edge N.
  - One pair per cycle at full throughput.
  - `result_valid` rises after the edge that accepts the last beat, giving 1-cycle latency.
- Length-0 vector: `result_valid`=1 after edge N+1... specifically after the edge accepting `start`, with value 0.
- Best-case back-to-back: `result_ready` tied high gives DONE for exactly 1 cycle, IDLE for 1 cycle, then the next `start` is accepted. Minimum period is `vector_length`+2 cycles.
- `mac_add_value` always equals the accumulator register, with no combinational path from the inputs.

## Test plan
- Reset: hold `reset_n`=0, release with `start`=0 -> all outputs 0, state IDLE, `busy`=0.
- Signed sum: `vector_length`=3, pairs (2,3), (5,2), (255,6) with no gaps -> `result_value`=10 (6+10-6), `result_valid` exactly 1 cycle after the third beat.
- Stalls and backpressure: same vector with `in_valid` deasserted 2 cycles between beats, then `result_ready` low 5 cycles -> the result is still 10, `result_value` stable across all 5 stall cycles, `in_ready` low throughout DONE.
- Wrap-around with DATA_WIDTH=8: 5 pairs of (127,127) -> 80645 mod 65536 = 15109. A second vector with `vector_length`=0 -> `result_value`=0 one cycle after `start`.
- Asynchronous reset mid-vector: assert `reset_n`=0 between edges after 2 of 4 beats -> outputs zero immediately. A fresh vector of 2 pairs (1,1), (1,1) -> result 2, with no leftover sum.
- `start` held high throughout a 2-pair run -> ignored while busy, and the next run begins only after the DONE handshake.
